pitch_cal_seq: RTL
==================

// Module: pitch_cal_seq
// PURPOSE
//  Calibration sequencer for the pitch-side LC DPLL. On start: flushes the DPLL LPF,
//  waits a programmed settle time, then averages 2^AVG_SHR LPF samples into a held
//  offset (antenna "null" value) for software to read. Owns the LPF latch/enable
//  strobes that feed the DPLL; sits beside the pitch register, in the SPDIF clock domain.
// PARAMETERS
//  DATA_W     32  width of lpf_i / cal_o
//  DIV_W      12  width of latch period divider (div_i)
//  SETTLE_W   16  width of settle count (settle_i), in latch strobes
//  AVG_SHR    4   log2 of samples averaged (16 samples)
// PORTS
//  clk_i        in   1          clock (single domain)
//  rst_n_i      in   1          reset, asynchronous, active-low
//  start_i      in   1          calibration request pulse, active high
//  abort_i      in   1          abort pulse, active high
//  div_i        in   DIV_W      latch period minus one, in clocks
//  settle_i     in   SETTLE_W   settle length, in latch strobes
//  lpf_i        in   DATA_W     LPF output from DPLL (unsigned)
//  lpf_ltch_o   out  1          LPF latch strobe to DPLL
//  lpf_en_o     out  1          LPF enable to DPLL
//  busy_o       out  1          sequence in progress
//  done_o       out  1          one-cycle pulse: new cal_o valid
//  cal_o        out  DATA_W     held averaged offset
//  cal_vld_o    out  1          cal_o holds a completed result (sticky)
// BEHAVIOUR
//  - Reset: lpf_ltch_o=0, lpf_en_o=1, busy_o=0, done_o=0, cal_o=0, cal_vld_o=0, FSM=IDLE,
//    divider=0, accumulator=0. Clock and reset are the only async signals; all else sync.
//  - Divider: free-running 0..div_i; lpf_ltch_o high for exactly the one cycle count==div_i,
//    then wraps to 0. div_i=0 -> strobe every cycle. div_i changes take effect at next wrap.
//    Runs in every state, so the DPLL LPF is always latched.
//  - FSM states: IDLE, FLUSH, SETTLE, ACC, DONE.
//    IDLE:   lpf_en_o=1, busy_o=0. start_i -> FLUSH (next cycle busy_o=1).
//    FLUSH:  lpf_en_o=0 until next lpf_ltch_o (inclusive); then -> SETTLE, or -> ACC
//            if settle_i==0. Settle counter loaded with settle_i on exit.
//    SETTLE: lpf_en_o=1; decrement on each strobe; at 0 -> ACC, accumulator cleared.
//    ACC:    sample lpf_i on the cycle after each lpf_ltch_o (DPLL output 1-cycle latency);
//            acc += lpf_i, acc width DATA_W+AVG_SHR (no overflow possible). After the
//            2^AVG_SHR-th sample -> DONE.
//    DONE:   one cycle: cal_o <= acc >> AVG_SHR (truncate), cal_vld_o<=1, done_o=1; -> IDLE.
//  - Latency, start to done_o: FLUSH (<= div_i+1) + settle_i strobes + 2^AVG_SHR strobes + 2.
//  - start_i while busy_o=1: ignored. abort_i in any non-IDLE state: -> IDLE next cycle,
//    lpf_en_o=1, no done_o, cal_o/cal_vld_o unchanged. abort_i and start_i same cycle in
//    IDLE: abort wins (stays IDLE). abort_i in IDLE: no effect.
//  - settle_i sampled only on FLUSH exit; div_i/settle_i changes mid-sequence do not
//    restart it.
//  - Async reset mid-sequence: all state to reset values immediately, cal_vld_o cleared.
// CONFIGURATION
//  - PITCH_CAL_ROUND_EN defined: DONE computes cal_o = (acc + 2^(AVG_SHR-1)) >> AVG_SHR
//    (round half up; adder is DATA_W+AVG_SHR+1 wide, result saturates to all-ones).
//  - Not defined: truncating shift as above; no rounding adder instantiated.
// TESTING
//  1 Reset release, no start: lpf_en_o=1, busy_o=0, cal_vld_o=0; div_i=3 -> lpf_ltch_o every 4th clk.
//  2 div_i=3, settle_i=2, lpf_i=1000 const, start pulse -> done_o after FLUSH+2+16 strobes,
//    cal_o=1000, cal_vld_o=1; lpf_en_o=0 only during FLUSH.
//  3 lpf_i alternating 7/8 each sample (AVG_SHR=4): cal_o=7 truncating;
//    cal_o=8 with PITCH_CAL_ROUND_EN.
//  4 abort_i on 5th ACC sample: IDLE next clk, no done_o, cal_o keeps previous 1000.
//  5 settle_i=0, div_i=0: FLUSH 1 clk, ACC takes 16 clks, done_o; start_i during busy ignored.
//  6 lpf_i=32'hFFFF_FFFF all samples: no overflow, cal_o=FFFF_FFFF (both configs);
//    rst_n_i low mid-ACC -> all outputs to reset values.

Source files
------------

// File: rtl/pitch_cal_seq.sv
// Pitch-side DPLL calibration sequencer: flush LPF, settle, average 2^AVG_SHR LPF samples.
// Build option PITCH_CAL_ROUND_EN: round the average half-up (saturating) instead of truncating.
module pitch_cal_seq #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DIV_W    = 12,
  parameter int unsigned SETTLE_W = 16,
  parameter int unsigned AVG_SHR  = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [DIV_W-1:0]    div_i,
  input  logic [SETTLE_W-1:0] settle_i,
  input  logic [DATA_W-1:0]   lpf_i,
  output logic                lpf_ltch_o,
  output logic                lpf_en_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [DATA_W-1:0]   cal_o,
  output logic                cal_vld_o
);

  localparam int unsigned AccW = DATA_W + AVG_SHR;

  typedef enum logic [2:0] {StIdle, StFlush, StSettle, StAcc, StDone} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d, per_q, per_d;
  logic                ltch_q, ltch_d;
  logic [SETTLE_W-1:0] set_q, set_d;
  logic [AccW-1:0]     acc_q, acc_d, sum;
  logic [AVG_SHR-1:0]  n_q, n_d;
  logic                smp_q, smp_d;
  logic [DATA_W-1:0]   cal_q, cal_d, avg;
  logic                vld_q, vld_d;

  // Period is reloaded only at wrap; strobe is registered so it is low during reset.
  always_comb begin
    if (cnt_q == per_q) begin
      cnt_d = '0;
      per_d = div_i;
    end else begin
      cnt_d = cnt_q + 1'b1;
      per_d = per_q;
    end
    ltch_d = (cnt_d == per_d);
  end

  assign sum = acc_q + AccW'(lpf_i);

`ifdef PITCH_CAL_ROUND_EN
  localparam logic [AccW:0] Half = (AccW + 1)'(1) << (AVG_SHR - 1);
  logic [AccW:0] rnd;
  always_comb begin
    rnd = ({1'b0, sum} + Half) >> AVG_SHR;
    avg = (rnd[AccW:DATA_W] != '0) ? '1 : rnd[DATA_W-1:0];
  end
`else
  assign avg = DATA_W'(sum >> AVG_SHR);
`endif

  always_comb begin
    state_d  = state_q;
    set_d    = set_q;
    acc_d    = acc_q;
    n_d      = n_q;
    smp_d    = 1'b0;
    cal_d    = cal_q;
    vld_d    = vld_q;
    lpf_en_o = 1'b1;
    busy_o   = 1'b1;
    done_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy_o = 1'b0;
        if (start_i && !abort_i) state_d = StFlush;
      end
      StFlush: begin
        lpf_en_o = 1'b0;
        if (ltch_q) begin
          set_d   = settle_i;
          acc_d   = '0;
          n_d     = '0;
          state_d = (settle_i == '0) ? StAcc : StSettle;
        end
      end
      StSettle: begin
        if (ltch_q) begin
          set_d = set_q - 1'b1;
          if (set_q == SETTLE_W'(1)) state_d = StAcc;
        end
      end
      StAcc: begin
        // DPLL output lags its latch strobe by one clock.
        if (smp_q) begin
          acc_d = sum;
          n_d   = n_q + 1'b1;
          if (n_q == '1) begin
            state_d = StDone;
            cal_d   = avg;
            vld_d   = 1'b1;
          end
        end
        smp_d = ltch_q && (state_d == StAcc);
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
      smp_d   = 1'b0;
      cal_d   = cal_q;
      vld_d   = vld_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      per_q   <= '0;
      ltch_q  <= 1'b0;
      set_q   <= '0;
      acc_q   <= '0;
      n_q     <= '0;
      smp_q   <= 1'b0;
      cal_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      ltch_q  <= ltch_d;
      set_q   <= set_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      smp_q   <= smp_d;
      cal_q   <= cal_d;
      vld_q   <= vld_d;
    end
  end

  assign lpf_ltch_o = ltch_q;
  assign cal_o      = cal_q;
  assign cal_vld_o  = vld_q;

endmodule
